// File: rtl/dp_gen2_pkg.sv
// Shared definitions for the datapath_gen2 slice: ALU/shift codes,
// writeback select encodings, status flag positions and the
// multiplier sequencer states.
package dp_gen2_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_NOT = 3'b011,
        ALU_MUL = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    // Multiplier sequencer state; exported so checkers can observe it.
    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

    localparam logic [3:0] VSEL_MDATA  = 4'b0001;
    localparam logic [3:0] VSEL_SXIMM8 = 4'b0010;
    localparam logic [3:0] VSEL_PC     = 4'b0100;
    localparam logic [3:0] VSEL_C      = 4'b1000;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

endpackage

// File: rtl/dp_seq_mul.sv
// Iterative shift-add multiplier. One multiplier bit is retired per
// cycle, so a start is followed by exactly WIDTH cycles in MUL_RUN.
// Only the low WIDTH bits of the product are accumulated.
// Handshake: i_start is honoured only in MUL_IDLE; o_finish is high
// during the final run cycle, and o_result is the completed product
// during that cycle so the caller can capture it on the closing edge.
module dp_seq_mul
    import dp_gen2_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output mul_state_e       o_state,
    output logic             o_finish,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH);

    mul_state_e       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    // Sequencer: latch operands on start, then add-and-shift once per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MUL_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    r_acc <= w_acc_next;
                    r_a   <= {r_a[WIDTH-2:0], 1'b0};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= MUL_IDLE;
                    end
                end
                default: r_state <= MUL_IDLE;
            endcase
        end
    end

    assign o_state  = r_state;
    assign o_finish = (r_state == MUL_RUN) && w_last;
    assign o_result = w_acc_next;

endmodule

// File: rtl/datapath_gen2.sv
// datapath_gen2: register file, A/B operand registers, B-side shifter,
// ALU with an iterative multiply, C result register and {V,N,Z} status.
// Optional macro DP_BYPASS_EN forwards same-cycle writeback data to the
// read port when the write and read indices match.
// Handshake: a MUL starts when alu_op=MUL, loadc=1 and busy=0; busy then
// stays high for WIDTH cycles, C is written on the edge closing the last
// busy cycle, and done pulses for the single following cycle.
module datapath_gen2
    import dp_gen2_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PC_W  = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         mdata,
    input  logic [WIDTH-1:0]         sximm8,
    input  logic [WIDTH-1:0]         sximm5,
    input  logic [PC_W-1:0]          pc,
    input  logic [3:0]               vsel,
    input  logic [$clog2(NREGS)-1:0] writenum,
    input  logic                     write,
    input  logic [$clog2(NREGS)-1:0] readnum,
    input  logic                     loada,
    input  logic                     loadb,
    input  logic                     asel,
    input  logic                     bsel,
    input  logic [1:0]               shift,
    input  logic [2:0]               alu_op,
    input  logic                     loadc,
    input  logic                     loads,
    output logic [WIDTH-1:0]         c_out,
    output logic [2:0]               status,
    output logic                     busy,
    output logic                     done
);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [2:0]       r_status;
    logic             r_done;
    logic             r_mul_loads;

    logic [WIDTH-1:0] w_wdata;
    logic             w_vsel_ok;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] w_bsh;
    logic [WIDTH-1:0] w_ain;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_alu;
    logic             w_v;
    alu_op_e          w_op;
    shift_e           w_shift;
    mul_state_e       w_mul_state;
    logic             w_mul_finish;
    logic [WIDTH-1:0] w_mul_result;
    logic             w_busy;
    logic             w_mul_start;

    assign w_op    = alu_op_e'(alu_op);
    assign w_shift = shift_e'(shift);

    // Writeback source select; anything other than a single hot bit is invalid.
    always_comb begin
        w_wdata   = '0;
        w_vsel_ok = 1'b1;
        case (vsel)
            VSEL_MDATA:  w_wdata = mdata;
            VSEL_SXIMM8: w_wdata = sximm8;
            VSEL_PC:     w_wdata = WIDTH'(pc);
            VSEL_C:      w_wdata = r_c;
            default: begin
                w_wdata   = '0;
                w_vsel_ok = 1'b0;
            end
        endcase
    end

    assign w_wr_en = write && w_vsel_ok;

`ifdef DP_BYPASS_EN
    assign w_rdata = (w_wr_en && (writenum == readnum)) ? w_wdata : r_regs[readnum];
`else
    assign w_rdata = r_regs[readnum];
`endif

    // Register file: single write port, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[writenum] <= w_wdata;
        end
    end

    // Operand registers load from the read port, independent of busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            if (loada) r_a <= w_rdata;
            if (loadb) r_b <= w_rdata;
        end
    end

    // B-side shifter.
    always_comb begin
        w_bsh = r_b;
        case (w_shift)
            SH_NONE: w_bsh = r_b;
            SH_LSL1: w_bsh = {r_b[WIDTH-2:0], 1'b0};
            SH_LSR1: w_bsh = {1'b0, r_b[WIDTH-1:1]};
            SH_ASR1: w_bsh = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
            default: w_bsh = r_b;
        endcase
    end

    assign w_ain = asel ? '0 : r_a;
    assign w_bin = bsel ? sximm5 : w_bsh;

    // Single-cycle ALU; V is only meaningful for ADD/SUB.
    always_comb begin
        w_alu = '0;
        w_v   = 1'b0;
        case (w_op)
            ALU_ADD: begin
                w_alu = w_ain + w_bin;
                w_v   = (w_ain[WIDTH-1] == w_bin[WIDTH-1]) && (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
            end
            ALU_SUB: begin
                w_alu = w_ain - w_bin;
                w_v   = (w_ain[WIDTH-1] != w_bin[WIDTH-1]) && (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
            end
            ALU_AND: w_alu = w_ain & w_bin;
            ALU_NOT: w_alu = ~w_bin;
            default: w_alu = '0;
        endcase
    end

    assign w_busy      = (w_mul_state == MUL_RUN);
    assign w_mul_start = loadc && (w_op == ALU_MUL) && !w_busy;

    dp_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_mul_start),
        .i_a      (w_ain),
        .i_b      (w_bin),
        .o_state  (w_mul_state),
        .o_finish (w_mul_finish),
        .o_result (w_mul_result)
    );

    // C, status and done: hold while busy, capture the product when it finishes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c         <= '0;
            r_status    <= '0;
            r_done      <= 1'b0;
            r_mul_loads <= 1'b0;
        end else begin
            r_done <= w_mul_finish;
            if (w_busy) begin
                if (w_mul_finish) begin
                    r_c <= w_mul_result;
                    if (r_mul_loads) begin
                        r_status <= {1'b0, w_mul_result[WIDTH-1], (w_mul_result == '0)};
                    end
                end
            end else if (w_mul_start) begin
                r_mul_loads <= loads;
            end else begin
                if (loadc) r_c <= w_alu;
                if (loads) r_status <= {w_v, w_alu[WIDTH-1], (w_alu == '0)};
            end
        end
    end

    assign c_out  = r_c;
    assign status = r_status;
    assign busy   = w_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_datapath_gen2.sv
// Bench for datapath_gen2 (WIDTH=16, NREGS=8, PC_W=9): directed scenarios
// with literal expectations, then randomized traffic, all compared every
// cycle against an arithmetic model of the datapath.
module tb_datapath_gen2;

  localparam int W = 16;

  logic          clk;
  logic          reset;
  logic [W-1:0]  mdata, sximm8, sximm5;
  logic [8:0]    pc;
  logic [3:0]    vsel;
  logic [2:0]    writenum, readnum;
  logic          write, loada, loadb, asel, bsel;
  logic [1:0]    shift;
  logic [2:0]    alu_op;
  logic          loadc, loads;
  logic [W-1:0]  c_out;
  logic [2:0]    status;
  logic          busy, done;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  datapath_gen2 #(.WIDTH(16), .NREGS(8), .PC_W(9)) dut (
    .clk(clk), .reset(reset), .mdata(mdata), .sximm8(sximm8), .sximm5(sximm5),
    .pc(pc), .vsel(vsel), .writenum(writenum), .write(write), .readnum(readnum),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift),
    .alu_op(alu_op), .loadc(loadc), .loads(loads), .c_out(c_out),
    .status(status), .busy(busy), .done(done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [W-1:0] m_rf [8];
  logic [W-1:0] m_a, m_b, m_c, m_prod;
  logic [2:0]   m_st;
  logic         m_done, m_mul_loads;
  int           m_busy_left;

  always @(posedge clk) begin
    logic [W-1:0] wd, rd, bs, ain, bin, outv;
    logic [31:0]  p32;
    bit           vok, vflag;
    int           sa, sb, sr;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_a = '0; m_b = '0; m_c = '0; m_st = '0; m_done = 0;
      m_busy_left = 0; m_mul_loads = 0; m_prod = '0;
    end else begin
      vok = ($countones(vsel) == 1);
      wd = vsel[0] ? mdata : vsel[1] ? sximm8 : vsel[2] ? W'(pc) : m_c;
      rd = m_rf[readnum];
`ifdef DP_BYPASS_EN
      if (write && vok && writenum == readnum) rd = wd;
`endif
      case (shift)
        2'd1: bs = m_b * 2;
        2'd2: bs = m_b / 2;
        2'd3: bs = W'($signed(m_b) >>> 1);
        default: bs = m_b;
      endcase
      ain = asel ? '0 : m_a;
      bin = bsel ? sximm5 : bs;
      sa = $signed(ain);
      sb = $signed(bin);
      vflag = 0;
      outv = '0;
      case (alu_op)
        3'd0: begin sr = sa + sb; outv = W'(sr); vflag = (sr > 32767) || (sr < -32768); end
        3'd1: begin sr = sa - sb; outv = W'(sr); vflag = (sr > 32767) || (sr < -32768); end
        3'd2: outv = ain & bin;
        3'd3: outv = ~bin;
        default: outv = '0;
      endcase
      m_done = 0;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_c = m_prod;
          if (m_mul_loads) m_st = {1'b0, m_prod[W-1], m_prod == 0};
          m_done = 1;
        end
      end else if (loadc && alu_op == 3'd4) begin
        p32 = ain * bin;
        m_prod = p32[W-1:0];
        m_busy_left = W;
        m_mul_loads = loads;
      end else begin
        if (loadc) m_c = outv;
        if (loads) m_st = {vflag, outv[W-1], outv == 0};
      end
      if (write && vok) m_rf[writenum] = wd;
      if (loada) m_a = rd;
      if (loadb) m_b = rd;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_c_out", c_out, m_c);
      cmp("model_status", W'(status), W'(m_st));
      cmp("model_busy", W'(busy), W'(m_busy_left > 0));
      cmp("model_done", W'(done), W'(m_done));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 0; loada = 0; loadb = 0; loadc = 0; loads = 0;
    asel = 0; bsel = 0; shift = 2'd0; alu_op = 3'd0; vsel = 4'b0010;
  endtask

  task automatic wr_imm(input logic [2:0] idx, input logic [W-1:0] val);
    vsel = 4'b0010; sximm8 = val; writenum = idx; write = 1;
    tick();
    write = 0;
  endtask

  task automatic ld_ab(input logic [2:0] ra, input logic [2:0] rb);
    readnum = ra; loada = 1;
    tick();
    loada = 0; readnum = rb; loadb = 1;
    tick();
    loadb = 0;
  endtask

  task automatic alu(input logic [2:0] op, input logic [1:0] sh, input logic bs, input logic ls);
    alu_op = op; shift = sh; bsel = bs; asel = 0; loadc = 1; loads = ls;
    tick();
    loadc = 0; loads = 0; shift = 2'd0; bsel = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nbusy, ndone;
    logic [W-1:0] exp_v;
    reset = 1; mdata = '0; sximm8 = '0; sximm5 = '0; pc = '0;
    writenum = '0; readnum = '0;
    idle();
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    cmp("reset_c_out", c_out, 16'h0);
    cmp("reset_status", W'(status), 16'h0);
    cmp("reset_busy", W'(busy), 16'h0);

    // Every register reads as zero after reset.
    sximm5 = '0;
    for (int i = 0; i < 8; i++) begin
      readnum = 3'(i); loada = 1;
      tick();
      loada = 0;
      alu(3'd0, 2'd0, 1'b1, 1'b1);
      cmp("reset_reg", c_out, 16'h0);
    end

    // ADD 5+3, SUB R2-R2.
    wr_imm(3'd1, 16'd5);
    wr_imm(3'd2, 16'd3);
    ld_ab(3'd1, 3'd2);
    alu(3'd0, 2'd0, 1'b0, 1'b1);
    cmp("add_5_3", c_out, 16'd8);
    cmp("add_5_3_status", W'(status), 16'h0);
    ld_ab(3'd2, 3'd2);
    alu(3'd1, 2'd0, 1'b0, 1'b1);
    cmp("sub_self", c_out, 16'd0);
    cmp("sub_self_status", W'(status), 16'h1);

    // Signed overflow, then ASR feeding NOT.
    wr_imm(3'd3, 16'h7FFF);
    wr_imm(3'd4, 16'h0001);
    ld_ab(3'd3, 3'd4);
    alu(3'd0, 2'd0, 1'b0, 1'b1);
    cmp("add_ovf", c_out, 16'h8000);
    cmp("add_ovf_status", W'(status), 16'h6);
    wr_imm(3'd5, 16'h8002);
    ld_ab(3'd3, 3'd5);
    alu(3'd3, 2'd3, 1'b0, 1'b0);
    cmp("not_asr", c_out, 16'h3FFE);

    // MUL 7x6 with a mid-busy loadc that must be ignored.
    wr_imm(3'd6, 16'd7);
    wr_imm(3'd7, 16'd6);
    ld_ab(3'd6, 3'd7);
    alu(3'd4, 2'd0, 1'b0, 1'b1);
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        cmp("mul_7_6", c_out, 16'd42);
        cmp("mul_7_6_status", W'(status), 16'h0);
      end
      if (i == 5) begin alu_op = 3'd0; loadc = 1; loads = 1; end
      tick();
      loadc = 0; loads = 0;
    end
    cmp("mul_busy_cycles", W'(nbusy), 16'd16);
    cmp("mul_done_pulses", W'(ndone), 16'd1);

    // MUL 0x100 x 0x100 wraps to zero.
    wr_imm(3'd1, 16'h0100);
    wr_imm(3'd2, 16'h0100);
    ld_ab(3'd1, 3'd2);
    alu(3'd4, 2'd0, 1'b0, 1'b1);
    ndone = 0;
    for (int i = 0; i < 40 && ndone == 0; i++) begin
      if (done) ndone++;
      else tick();
    end
    cmp("mul_wrap_done_seen", W'(ndone), 16'd1);
    cmp("mul_wrap", c_out, 16'h0);
    cmp("mul_wrap_status", W'(status), 16'h1);

    // Reset during busy cycle 5 aborts the multiply.
    alu(3'd4, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    cmp("mul_abort_busy_before", W'(busy), 16'd1);
    reset = 1;
    tick();
    reset = 0;
    cmp("abort_busy", W'(busy), 16'd0);
    cmp("abort_c_out", c_out, 16'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      tick();
    end
    cmp("abort_no_done", W'(ndone), 16'd0);

    // Same-cycle write/read of R3, then an invalid vsel write.
    wr_imm(3'd3, 16'd4);
    vsel = 4'b0010; sximm8 = 16'd9; writenum = 3'd3; readnum = 3'd3;
    write = 1; loada = 1;
    tick();
    write = 0; loada = 0;
    sximm5 = '0;
    alu(3'd0, 2'd0, 1'b1, 1'b0);
`ifdef DP_BYPASS_EN
    exp_v = 16'd9;
`else
    exp_v = 16'd4;
`endif
    cmp("same_cycle_rw", c_out, exp_v);
    vsel = 4'b0011; sximm8 = 16'd7; writenum = 3'd3; write = 1;
    tick();
    write = 0;
    readnum = 3'd3; loada = 1;
    tick();
    loada = 0;
    alu(3'd0, 2'd0, 1'b1, 1'b0);
    cmp("bad_vsel_no_write", c_out, 16'd9);

    // Randomized traffic, checked by the model.
    for (int i = 0; i < 1500; i++) begin
      mdata = W'($urandom); sximm8 = W'($urandom); sximm5 = W'($urandom);
      pc = 9'($urandom);
      case ($urandom_range(0, 9))
        0: vsel = 4'($urandom);
        1, 2: vsel = 4'b0001;
        3, 4: vsel = 4'b0010;
        5, 6: vsel = 4'b0100;
        default: vsel = 4'b1000;
      endcase
      writenum = 3'($urandom); readnum = 3'($urandom);
      write = ($urandom_range(0, 1) == 1);
      loada = ($urandom_range(0, 2) == 0);
      loadb = ($urandom_range(0, 2) == 0);
      asel = ($urandom_range(0, 4) == 0);
      bsel = ($urandom_range(0, 2) == 0);
      shift = 2'($urandom);
      alu_op = 3'($urandom);
      loadc = ($urandom_range(0, 2) == 0);
      loads = ($urandom_range(0, 1) == 1);
      if (alu_op == 3'd4 && !loadc) loads = 0;
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
